// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: shares single-port frame memory between display reads and host writes,
// with vblank/starvation priority, bus turnaround and read-return tracking.
module frame_mem_arbiter #(
  parameter int DATA_W        = 24,
  parameter int ADDR_W        = 19,
  parameter int READ_LAT      = 2,
  parameter int HOST_MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vblank,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic              o_disp_gnt,
  output logic              o_disp_rvalid,
  output logic [DATA_W-1:0] o_disp_rdata,
  input  logic              i_host_req,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_wdata,
  output logic              o_host_gnt,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);
  localparam int CW = $clog2(HOST_MAX_WAIT + 1);
  typedef enum logic [1:0] {IDLE, RD, WR, TURN} state_t;
  state_t              r_state, w_next;
  logic [CW-1:0]       r_wait_cnt;
  logic [READ_LAT-1:0] r_rd_pipe;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_host_win, w_disp_win, w_rd, w_wr;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_rd_pipe  <= '0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= (!i_host_req || w_wr) ? '0 :
                    (r_wait_cnt == CW'(HOST_MAX_WAIT)) ? r_wait_cnt : r_wait_cnt + CW'(1);
      r_rd_pipe  <= READ_LAT'({r_rd_pipe, w_rd});
      r_rvalid   <= r_rd_pipe[READ_LAT-1];
      if (r_rd_pipe[READ_LAT-1]) r_rdata <= i_mem_rdata;
    end
  end
  // a winner that needs the opposite bus direction spends this cycle in TURN instead
  always_comb begin
    w_host_win = !rst && i_host_req &&
                 (!i_disp_req || i_vblank || r_wait_cnt == CW'(HOST_MAX_WAIT));
    w_disp_win = !rst && i_disp_req && !w_host_win;
    w_rd       = w_disp_win && r_state != WR;
    w_wr       = w_host_win && r_state != RD;
    w_next     = w_disp_win ? ((r_state == WR) ? TURN : RD) :
                 w_host_win ? ((r_state == RD) ? TURN : WR) : IDLE;
  end
  assign o_disp_gnt    = w_rd;
  assign o_host_gnt    = w_wr;
  assign o_mem_en      = w_rd | w_wr;
  assign o_mem_we      = w_wr;
  assign o_mem_addr    = w_wr ? i_host_addr : w_rd ? i_disp_addr : '0;
  assign o_mem_wdata   = w_wr ? i_host_wdata : '0;
  assign o_disp_rvalid = r_rvalid;
  assign o_disp_rdata  = r_rdata;
endmodule
